ex_mem_skid: RTL and testbench

EX_MEM_SKID -- requirements
Module: ex_mem_skid

---
 rtl/ex_mem_skid_pkg.sv | 33 +++
 rtl/ex_mem_skid.sv | 136 +++++++++++++
 tb/tb_ex_mem_skid.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_skid_pkg.sv
// Shared rv32i widths, EX/MEM record layout, ctrl bit positions and skid FSM encodings.
package ex_mem_skid_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 4;

  // ctrl = {reg_write, mem_read, mem_write, is_branch}
  localparam int CTRL_REG_WRITE = 3;
  localparam int CTRL_MEM_READ  = 2;
  localparam int CTRL_MEM_WRITE = 1;
  localparam int CTRL_IS_BRANCH = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [XLEN-1:0]   alu_result;
    logic              branch_ena;
    logic [XLEN-1:0]   branch_tgt;
    logic [XLEN-1:0]   store_data;
    logic [REG_AW-1:0] rd;
    logic [CTRL_W-1:0] ctrl;
  } ex_mem_rec_t;

  function automatic logic rec_taken(input ex_mem_rec_t r);
    return r.branch_ena & r.ctrl[CTRL_IS_BRANCH];
  endfunction

endpackage

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register as a 2-entry skid buffer; 1-cycle latency, ex_ready_o is a flop.
// Optional taken-branch counter enabled by defining EX_MEM_TAKEN_CNT_EN.
module ex_mem_skid
  import ex_mem_skid_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [XLEN-1:0]   alu_result_i,
  input  logic              branch_ena_i,
  input  logic [XLEN-1:0]   branch_tgt_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [XLEN-1:0]   alu_result_o,
  output logic              branch_taken_o,
  output logic [XLEN-1:0]   branch_tgt_o,
  output logic [XLEN-1:0]   store_data_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [CTRL_W-1:0] ctrl_o
`ifdef EX_MEM_TAKEN_CNT_EN
  ,
  output logic [31:0]       taken_cnt_o
`endif
);

  skid_state_t state_q, state_d;
  ex_mem_rec_t main_q, skid_q, in_rec;
  logic        rdy_q;
  logic        accept, emit;
  logic        load_main, load_skid, skid_to_main;

  assign in_rec = '{alu_result: alu_result_i, branch_ena: branch_ena_i,
                    branch_tgt: branch_tgt_i, store_data: store_data_i,
                    rd: rd_i, ctrl: ctrl_i};

  assign mem_valid_o = (state_q != ST_EMPTY);
  assign accept      = ex_valid_i & rdy_q;
  assign emit        = mem_valid_o & mem_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != ST_TWO);
    end
  end

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (emit) begin
            state_d      = ST_ONE;
            skid_to_main = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q <= '0;
    end else if (flush_i) begin
      main_q.ctrl <= '0;
    end else if (load_main) begin
      main_q <= in_rec;
    end else if (skid_to_main) begin
      main_q <= skid_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_q <= '0;
    end else if (flush_i) begin
      skid_q.ctrl <= '0;
    end else if (load_skid) begin
      skid_q <= in_rec;
    end
  end

  // Stale ctrl bits in an emptied main entry must never reach MEM.
  assign ex_ready_o     = rdy_q;
  assign alu_result_o   = main_q.alu_result;
  assign branch_tgt_o   = main_q.branch_tgt;
  assign store_data_o   = main_q.store_data;
  assign rd_o           = main_q.rd;
  assign ctrl_o         = mem_valid_o ? main_q.ctrl : '0;
  assign branch_taken_o = main_q.branch_ena & ctrl_o[CTRL_IS_BRANCH];

`ifdef EX_MEM_TAKEN_CNT_EN
  logic [31:0] taken_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      taken_cnt_q <= '0;
    end else if (emit && branch_taken_o) begin
      taken_cnt_q <= taken_cnt_q + 32'd1;
    end
  end

  assign taken_cnt_o = taken_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// Randomized + directed bench for ex_mem_skid against a queue-based record model.
module tb_ex_mem_skid;
  import ex_mem_skid_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush_i = 1'b0;
  logic              ex_valid_i = 1'b0;
  logic              ex_ready_o;
  logic [XLEN-1:0]   alu_result_i = '0;
  logic              branch_ena_i = 1'b0;
  logic [XLEN-1:0]   branch_tgt_i = '0;
  logic [XLEN-1:0]   store_data_i = '0;
  logic [REG_AW-1:0] rd_i = '0;
  logic [CTRL_W-1:0] ctrl_i = '0;
  logic              mem_valid_o;
  logic              mem_ready_i = 1'b0;
  logic [XLEN-1:0]   alu_result_o;
  logic              branch_taken_o;
  logic [XLEN-1:0]   branch_tgt_o;
  logic [XLEN-1:0]   store_data_o;
  logic [REG_AW-1:0] rd_o;
  logic [CTRL_W-1:0] ctrl_o;
`ifdef EX_MEM_TAKEN_CNT_EN
  logic [31:0]       taken_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  ex_mem_skid dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .alu_result_i(alu_result_i), .branch_ena_i(branch_ena_i),
    .branch_tgt_i(branch_tgt_i), .store_data_i(store_data_i),
    .rd_i(rd_i), .ctrl_i(ctrl_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .alu_result_o(alu_result_o), .branch_taken_o(branch_taken_o),
    .branch_tgt_o(branch_tgt_o), .store_data_o(store_data_o),
    .rd_o(rd_o), .ctrl_o(ctrl_o)
`ifdef EX_MEM_TAKEN_CNT_EN
    , .taken_cnt_o(taken_cnt_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Model: FIFO of up to two held records, plus the registered ready flag.
  ex_mem_rec_t q[$];
  logic        mdl_rdy = 1'b0;
  logic [31:0] mdl_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    chk("mem_valid", {31'd0, mem_valid_o}, {31'd0, q.size() > 0});
    chk("ex_ready", {31'd0, ex_ready_o}, {31'd0, mdl_rdy});
    if (q.size() > 0) begin
      chk("alu_result", alu_result_o, q[0].alu_result);
      chk("branch_tgt", branch_tgt_o, q[0].branch_tgt);
      chk("store_data", store_data_o, q[0].store_data);
      chk("rd", {27'd0, rd_o}, {27'd0, q[0].rd});
      chk("ctrl", {28'd0, ctrl_o}, {28'd0, q[0].ctrl});
      chk("branch_taken", {31'd0, branch_taken_o}, {31'd0, q[0].branch_ena & q[0].ctrl[CTRL_IS_BRANCH]});
    end else begin
      chk("ctrl_empty", {28'd0, ctrl_o}, 32'd0);
      chk("taken_empty", {31'd0, branch_taken_o}, 32'd0);
    end
`ifdef EX_MEM_TAKEN_CNT_EN
    chk("taken_cnt", taken_cnt_o, mdl_cnt);
`endif
  end

  // Present one input set from posedge+1 through the next posedge, advance the model there.
  task automatic cycle(input logic v, input ex_mem_rec_t r, input logic mr, input logic fl);
    ex_mem_rec_t f;
    logic        emit, acc;
    ex_valid_i   = v;
    alu_result_i = r.alu_result;
    branch_ena_i = r.branch_ena;
    branch_tgt_i = r.branch_tgt;
    store_data_i = r.store_data;
    rd_i         = r.rd;
    ctrl_i       = r.ctrl;
    mem_ready_i  = mr;
    flush_i      = fl;
    @(posedge clk_i);
    if (rst_ni) begin
      emit = (q.size() > 0) && mr;
      acc  = v && mdl_rdy;
      if (emit) begin
        f = q.pop_front();
        if (f.branch_ena && f.ctrl[CTRL_IS_BRANCH]) mdl_cnt = mdl_cnt + 32'd1;
      end
      if (fl) q.delete();
      else if (acc) q.push_back(r);
      mdl_rdy = (q.size() < 2);
    end
    #1;
  endtask

  function automatic ex_mem_rec_t mk(input logic [31:0] alu, input logic ena,
                                     input logic [31:0] tgt, input logic [3:0] ctl);
    ex_mem_rec_t r;
    r.alu_result = alu;
    r.branch_ena = ena;
    r.branch_tgt = tgt;
    r.store_data = ~alu;
    r.rd         = alu[4:0];
    r.ctrl       = ctl;
    return r;
  endfunction

  function automatic ex_mem_rec_t rnd_rec();
    ex_mem_rec_t r;
    r.alu_result = $urandom;
    r.branch_ena = 1'($urandom_range(0, 1));
    r.branch_tgt = $urandom;
    r.store_data = $urandom;
    r.rd         = 5'($urandom_range(0, 31));
    r.ctrl       = 4'($urandom_range(0, 15));
    return r;
  endfunction

  ex_mem_rec_t idle;

  initial begin
    idle = mk(32'h0, 1'b0, 32'h0, 4'h0);
    #3;
    chk("rst_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("rst_ready", {31'd0, ex_ready_o}, 32'd0);
    chk("rst_alu", alu_result_o, 32'd0);
    chk("rst_tgt", branch_tgt_o, 32'd0);
    chk("rst_sd", store_data_o, 32'd0);
    chk("rst_rd", {27'd0, rd_o}, 32'd0);
    chk("rst_ctrl", {28'd0, ctrl_o}, 32'd0);
    repeat (2) cycle(1'b1, mk(32'h77, 1'b1, 32'h1, 4'hF), 1'b1, 1'b0);
    chk("rst_hold_ready", {31'd0, ex_ready_o}, 32'd0);
    #2 rst_ni = 1'b1;
    cycle(1'b0, idle, 1'b1, 1'b0);
    chk("ready_after_rst", {31'd0, ex_ready_o}, 32'd1);

    // First record appears one cycle after acceptance.
    cycle(1'b1, mk(32'h0000_1234, 1'b0, 32'h0, 4'h8), 1'b1, 1'b0);
    chk("lat_valid", {31'd0, mem_valid_o}, 32'd1);
    chk("lat_alu", alu_result_o, 32'h0000_1234);
    chk("lat_ready", {31'd0, ex_ready_o}, 32'd1);
    cycle(1'b0, idle, 1'b1, 1'b0);

    // Back-pressure fills the skid entry, then drains in order.
    cycle(1'b1, mk(32'hA, 1'b0, 32'h0, 4'h8), 1'b0, 1'b0);
    cycle(1'b1, mk(32'hB, 1'b0, 32'h0, 4'h8), 1'b0, 1'b0);
    chk("full_ready", {31'd0, ex_ready_o}, 32'd0);
    chk("full_head", alu_result_o, 32'hA);
    cycle(1'b0, idle, 1'b0, 1'b0);
    chk("stall_hold", alu_result_o, 32'hA);
    cycle(1'b0, idle, 1'b1, 1'b0);
    chk("drain_second", alu_result_o, 32'hB);
    chk("drain_ready", {31'd0, ex_ready_o}, 32'd1);
    cycle(1'b0, idle, 1'b1, 1'b0);
    chk("drain_empty", {31'd0, mem_valid_o}, 32'd0);

    // Flush while full drops everything including the input offered that cycle.
    cycle(1'b1, mk(32'hC, 1'b0, 32'h0, 4'hC), 1'b0, 1'b0);
    cycle(1'b1, mk(32'hD, 1'b0, 32'h0, 4'hC), 1'b0, 1'b0);
    cycle(1'b1, mk(32'hE, 1'b0, 32'h0, 4'hC), 1'b0, 1'b1);
    chk("flush_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("flush_ctrl", {28'd0, ctrl_o}, 32'd0);
    chk("flush_ready", {31'd0, ex_ready_o}, 32'd1);
    cycle(1'b0, idle, 1'b1, 1'b0);
    chk("flush_dropped", {31'd0, mem_valid_o}, 32'd0);

    // Branch-taken needs both the condition and is_branch.
    cycle(1'b1, mk(32'h5, 1'b1, 32'h0000_0200, 4'h8), 1'b0, 1'b0);
    chk("not_branch", {31'd0, branch_taken_o}, 32'd0);
    cycle(1'b0, idle, 1'b1, 1'b0);
    cycle(1'b1, mk(32'h6, 1'b1, 32'h0000_0100, 4'h1), 1'b0, 1'b0);
    chk("taken", {31'd0, branch_taken_o}, 32'd1);
    chk("taken_tgt", branch_tgt_o, 32'h0000_0100);
    cycle(1'b0, idle, 1'b1, 1'b0);

`ifdef EX_MEM_TAKEN_CNT_EN
    force dut.taken_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.taken_cnt_q;
    mdl_cnt = 32'hFFFF_FFFF;
    cycle(1'b1, mk(32'h7, 1'b1, 32'h40, 4'h1), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h8, 1'b0, 32'h40, 4'h1), 1'b1, 1'b0);
    chk("cnt_wrap", taken_cnt_o, 32'd0);
    cycle(1'b0, idle, 1'b1, 1'b0);
    chk("cnt_not_taken", taken_cnt_o, 32'd0);
`endif

    // Asynchronous reset while holding one record.
    cycle(1'b1, mk(32'hF, 1'b0, 32'h0, 4'h8), 1'b0, 1'b0);
    #1 rst_ni = 1'b0;
    q.delete();
    mdl_rdy = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("async_rst_ready", {31'd0, ex_ready_o}, 32'd0);
    cycle(1'b0, idle, 1'b1, 1'b0);
    #3 rst_ni = 1'b1;
    cycle(1'b0, idle, 1'b1, 1'b0);
    chk("async_rst_no_emit", {31'd0, mem_valid_o}, 32'd0);
    chk("async_rst_ready_up", {31'd0, ex_ready_o}, 32'd1);

    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 9) < 7, rnd_rec(), $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 3);
    end
    cycle(1'b0, idle, 1'b1, 1'b0);
    cycle(1'b0, idle, 1'b1, 1'b0);
    @(negedge clk_i);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
